// File: rtl/uart_frame_sched.sv
// Telemetry frame scheduler: snapshots four 16-bit words on request and streams
// a 10-byte frame (header, 8 LE data bytes, checksum) over a valid/ready byte port.
module uart_frame_sched #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        send_tick,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] set_x_in,
  input  logic [15:0] set_y_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = 9;
  localparam int unsigned CNT_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
  logic [15:0]      snap_x, snap_y, snap_sx, snap_sy;
  logic             load_snap;
  logic [7:0]       byte_data_nxt, drop_cnt_nxt, next_byte, checksum;
  logic             byte_valid_nxt, busy_nxt, frame_done_nxt;
  logic             auto_tick, accept, last_hs;

  // Free-running internal request tick, independent of enable and state
  generate
    if (AUTO_PERIOD == 0) begin : g_no_auto
      assign auto_tick = 1'b0;
    end else begin : g_auto
      logic [CNT_W-1:0] auto_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          auto_cnt <= '0;
        end else if (auto_cnt == CNT_W'(AUTO_PERIOD - 1)) begin
          auto_cnt <= '0;
        end else begin
          auto_cnt <= auto_cnt + CNT_W'(1);
        end
      end
      assign auto_tick = (auto_cnt == CNT_W'(AUTO_PERIOD - 1));
    end
  endgenerate

  assign accept  = (send_tick | auto_tick) & enable;
  assign last_hs = byte_ready && (idx == IDX_W'(LAST_IDX));
  assign idx_inc = idx + IDX_W'(1);

  assign checksum = snap_x[7:0]  + snap_x[15:8]  + snap_y[7:0]  + snap_y[15:8] +
                    snap_sx[7:0] + snap_sx[15:8] + snap_sy[7:0] + snap_sy[15:8];

  // Byte to present after the current one is accepted
  always_comb begin
    next_byte = checksum;
    case (idx_inc)
      4'd1:    next_byte = snap_x[7:0];
      4'd2:    next_byte = snap_x[15:8];
      4'd3:    next_byte = snap_y[7:0];
      4'd4:    next_byte = snap_y[15:8];
      4'd5:    next_byte = snap_sx[7:0];
      4'd6:    next_byte = snap_sx[15:8];
      4'd7:    next_byte = snap_sy[7:0];
      4'd8:    next_byte = snap_sy[15:8];
      default: next_byte = checksum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    byte_data_nxt  = byte_data;
    byte_valid_nxt = byte_valid;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    idx_nxt        = idx;
    drop_cnt_nxt   = drop_cnt;
    load_snap      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_snap      = 1'b1;
          byte_data_nxt  = HEADER;
          byte_valid_nxt = 1'b1;
          busy_nxt       = 1'b1;
          idx_nxt        = '0;
        end
      end
      SEND: begin
        // Requests are dropped up to and including the final handshake edge
        if (accept && (drop_cnt != 8'hFF)) drop_cnt_nxt = drop_cnt + 8'd1;
        if (last_hs) begin
          byte_valid_nxt = 1'b0;
          busy_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
        end else if (byte_ready) begin
          idx_nxt       = idx_inc;
          byte_data_nxt = next_byte;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      idx        <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_sx    <= '0;
      snap_sy    <= '0;
    end else begin
      byte_data  <= byte_data_nxt;
      byte_valid <= byte_valid_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      drop_cnt   <= drop_cnt_nxt;
      idx        <= idx_nxt;
      if (load_snap) begin
        snap_x  <= x_in;
        snap_y  <= y_in;
        snap_sx <= set_x_in;
        snap_sy <= set_y_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched: one task per scenario, inline checks,
// a second instance with AUTO_PERIOD=20 for the internal tick.
module tb_uart_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, send_tick, byte_ready;
  logic [15:0] x_in, y_in, set_x_in, set_y_in;
  logic [7:0]  byte_data, drop_cnt;
  logic        byte_valid, busy, frame_done;

  logic        send_tick2, byte_ready2;
  logic [7:0]  byte_data2, drop_cnt2;
  logic        byte_valid2, busy2, frame_done2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_b [10];

  always #5 clk = ~clk;

  uart_frame_sched #(.HEADER(8'hA5), .AUTO_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .send_tick(send_tick),
    .x_in(x_in), .y_in(y_in), .set_x_in(set_x_in), .set_y_in(set_y_in),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  uart_frame_sched #(.HEADER(8'hA5), .AUTO_PERIOD(20)) dut_auto (
    .clk(clk), .rst(rst), .enable(enable), .send_tick(send_tick2),
    .x_in(x_in), .y_in(y_in), .set_x_in(set_x_in), .set_y_in(set_y_in),
    .byte_data(byte_data2), .byte_valid(byte_valid2), .byte_ready(byte_ready2),
    .busy(busy2), .frame_done(frame_done2), .drop_cnt(drop_cnt2)
  );

  task automatic set_inputs();
    x_in = 16'h1234; y_in = 16'hABCD; set_x_in = 16'h0100; set_y_in = 16'h00FF;
  endtask

  // Ends at a sample point (#1 after an edge) with rst just released
  task automatic do_reset();
    rst = 1'b1; send_tick = 1'b0; enable = 1'b1; byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", byte_data); end
    total++; if (byte_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got valid=%b busy=%b done=%b want 0 0 0", byte_valid, busy, frame_done); end
    total++; if (drop_cnt !== 8'h00) begin bad++; $display("FAIL reset_drop: got %h want 00", drop_cnt); end
    total++; if (byte_valid2 !== 1'b0) begin bad++; $display("FAIL reset_auto_valid: got %b want 0", byte_valid2); end
  endtask

  task automatic test_basic();
    do_reset(); set_inputs();
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (byte_valid !== 1'b1 || byte_data !== exp_b[i]) begin
        bad++; $display("FAIL basic_byte%0d: got valid=%b data=%h want 1 %h", i, byte_valid, byte_data, exp_b[i]); end
      total++; if (busy !== 1'b1 || frame_done !== 1'b0) begin
        bad++; $display("FAIL basic_busy%0d: got busy=%b done=%b want 1 0", i, busy, frame_done); end
      @(posedge clk); #1;
    end
    total++; if (frame_done !== 1'b1 || busy !== 1'b0 || byte_valid !== 1'b0) begin
      bad++; $display("FAIL basic_done: got done=%b busy=%b valid=%b want 1 0 0", frame_done, busy, byte_valid); end
    // Request in the frame_done cycle starts the next frame immediately
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    total++; if (byte_valid !== 1'b1 || byte_data !== 8'hA5 || frame_done !== 1'b0 || drop_cnt !== 8'h00) begin
      bad++; $display("FAIL b2b_start: got valid=%b data=%h done=%b drop=%h want 1 a5 0 00",
                      byte_valid, byte_data, frame_done, drop_cnt); end
    repeat (10) @(posedge clk); #1;
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", frame_done); end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    logic        prev_wait;
    logic [7:0]  prev_data;
    int n, c;
    pat = 16'b1001_0110_1100_1010;
    do_reset(); set_inputs(); byte_ready = 1'b0;
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    n = 0; c = 0; prev_wait = 1'b0; prev_data = 8'h00;
    while (n < 10 && c < 200) begin
      total++; if (byte_valid !== 1'b1 || byte_data !== exp_b[n]) begin
        bad++; $display("FAIL bp_byte%0d: got valid=%b data=%h want 1 %h", n, byte_valid, byte_data, exp_b[n]); end
      if (prev_wait) begin
        total++; if (byte_data !== prev_data) begin
          bad++; $display("FAIL bp_stable: got %h want %h", byte_data, prev_data); end
      end
      if (n == 3) begin x_in = '0; y_in = '0; set_x_in = '0; set_y_in = '0; end
      byte_ready = pat[c % 16];
      prev_wait  = !byte_ready;
      prev_data  = byte_data;
      if (byte_ready) n++;
      c++;
      @(posedge clk); #1;
    end
    total++; if (n != 10) begin bad++; $display("FAIL bp_timeout: got %0d bytes want 10", n); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", frame_done); end
    byte_ready = 1'b1;
  endtask

  task automatic test_drops();
    do_reset(); set_inputs();
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (byte_data !== exp_b[i]) begin
        bad++; $display("FAIL drop_byte%0d: got %h want %h", i, byte_data, exp_b[i]); end
      send_tick = (i == 3 || i == 6 || i == 9);
      @(posedge clk); #1;
    end
    send_tick = 1'b0;
    total++; if (drop_cnt !== 8'd3 || frame_done !== 1'b1) begin
      bad++; $display("FAIL drop_count: got drop=%0d done=%b want 3 1", drop_cnt, frame_done); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (byte_valid !== 1'b0 || drop_cnt !== 8'd3) begin
        bad++; $display("FAIL drop_noframe%0d: got valid=%b drop=%0d want 0 3", k, byte_valid, drop_cnt); end
    end
  endtask

  task automatic test_saturate();
    do_reset(); set_inputs(); byte_ready = 1'b0;
    send_tick = 1'b1; @(posedge clk); #1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 254) begin
        total++; if (drop_cnt !== 8'hFE) begin bad++; $display("FAIL sat_254: got %h want fe", drop_cnt); end
      end
      if (k == 255) begin
        total++; if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL sat_255: got %h want ff", drop_cnt); end
      end
    end
    send_tick = 1'b0;
    total++; if (drop_cnt !== 8'hFF || byte_valid !== 1'b1 || byte_data !== 8'hA5) begin
      bad++; $display("FAIL sat_end: got drop=%h valid=%b data=%h want ff 1 a5", drop_cnt, byte_valid, byte_data); end
    byte_ready = 1'b1;
  endtask

  task automatic test_enable();
    do_reset(); set_inputs(); enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
      total++; if (byte_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00) begin
        bad++; $display("FAIL en_ignore%0d: got valid=%b busy=%b drop=%h want 0 0 00", p, byte_valid, busy, drop_cnt); end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (byte_valid !== 1'b1 || byte_data !== exp_b[i]) begin
        bad++; $display("FAIL en_byte%0d: got valid=%b data=%h want 1 %h", i, byte_valid, byte_data, exp_b[i]); end
      if (i == 2) enable = 1'b0;
      send_tick = (i == 5);
      @(posedge clk); #1;
    end
    send_tick = 1'b0;
    total++; if (frame_done !== 1'b1 || drop_cnt !== 8'h00) begin
      bad++; $display("FAIL en_done: got done=%b drop=%h want 1 00", frame_done, drop_cnt); end
    enable = 1'b1;
  endtask

  task automatic test_auto();
    int starts;
    logic prev;
    do_reset(); set_inputs();
    starts = 0; prev = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (byte_valid2 && !prev) begin
        total++; if (c != 20 * (starts + 1) || byte_data2 !== 8'hA5) begin
          bad++; $display("FAIL auto_start%0d: got cycle=%0d data=%h want %0d a5", starts, c, byte_data2, 20 * (starts + 1)); end
        starts++;
      end
      prev = byte_valid2;
    end
    total++; if (starts != 3) begin bad++; $display("FAIL auto_count: got %0d starts want 3", starts); end
    total++; if (drop_cnt2 !== 8'h00) begin bad++; $display("FAIL auto_drop: got %h want 00", drop_cnt2); end
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL auto_off: got valid=%b want 0", byte_valid); end
  endtask

  task automatic test_reset_midframe();
    do_reset(); set_inputs();
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_tick = (i == 1);
      @(posedge clk); #1;
    end
    send_tick = 1'b0;
    total++; if (drop_cnt !== 8'd1 || byte_data !== exp_b[5]) begin
      bad++; $display("FAIL rm_pre: got drop=%0d data=%h want 1 %h", drop_cnt, byte_data, exp_b[5]); end
    #2 rst = 1'b1;
    #1;
    total++; if (byte_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00 || byte_data !== 8'h00) begin
      bad++; $display("FAIL rm_async: got valid=%b busy=%b drop=%h data=%h want 0 0 00 00", byte_valid, busy, drop_cnt, byte_data); end
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL rm_idle%0d: got valid=%b want 0", k, byte_valid); end
    end
    send_tick = 1'b1; @(posedge clk); #1; send_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (byte_valid !== 1'b1 || byte_data !== exp_b[i]) begin
        bad++; $display("FAIL rm_byte%0d: got valid=%b data=%h want 1 %h", i, byte_valid, byte_data, exp_b[i]); end
      @(posedge clk); #1;
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rm_done: got %b want 1", frame_done); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; send_tick = 1'b0; byte_ready = 1'b1;
    send_tick2 = 1'b0; byte_ready2 = 1'b1;
    x_in = '0; y_in = '0; set_x_in = '0; set_y_in = '0;
    // 34+12+CD+AB+00+01+FF+00 = 0x2BE -> checksum BE
    exp_b = '{8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
    test_reset();
    test_basic();
    test_backpressure();
    test_drops();
    test_saturate();
    test_enable();
    test_auto();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_sched.md
Name: uart_frame_sched

Overview:
Scheduler that sequences one telemetry frame through a byte-level UART transmitter. The frame carries ball position x/y and setpoint x/y. On each send request, the block snapshots the four 16-bit words and builds a 10-byte frame: header, 8 little-endian data bytes, checksum. It hands the bytes one at a time to the downstream byte serializer over a valid/ready handshake, and counts requests it had to drop while busy.

Parameters:
HEADER, 8'hA5, first byte of every frame
AUTO_PERIOD, 0, internal tick period in clk cycles; 0 disables the internal tick so only send_tick starts frames

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = accept new frame requests; 0 = ignore requests, but a frame in flight still completes
send_tick  input  1  single-cycle frame request
x_in  input  16  current x position
y_in  input  16  current y position
set_x_in  input  16  x setpoint
set_y_in  input  16  y setpoint
byte_data  output  8  byte offered to the serializer
byte_valid  output  1  byte_data is valid
byte_ready  input  1  serializer accepts byte_data this cycle
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last byte is accepted
drop_cnt  output  8  saturating count of dropped requests

Behaviour:
- Reset (async, rst=1): byte_data=0, byte_valid=0, busy=0, frame_done=0, drop_cnt=0, state=IDLE, byte index=0, auto counter=0, snapshot registers=0.
- Request: req = send_tick OR auto_tick.
  - auto_tick is high for one cycle when auto counter == AUTO_PERIOD-1. The counter then wraps to 0.
  - The counter free-runs regardless of enable or state.
  - With AUTO_PERIOD=0, auto_tick is constant 0.
- States: IDLE, SEND.
- IDLE:
  - On an edge with req=1 and enable=1:
    - x/y/set_x/set_y snapshot <= inputs.
    - byte_data <= HEADER, byte_valid <= 1, busy <= 1, index <= 0.
    - Go to SEND.
  - Latency: byte_valid is high in the first cycle after the request.
  - req with enable=0 is ignored and not counted.
- SEND:
  - byte_valid stays high and byte_data stays stable until byte_ready=1 (standard valid/ready; byte_data must not change while waiting).
  - On an edge with byte_ready=1 and index<9: index <= index+1, byte_data <= next byte.
  - On an edge with byte_ready=1 and index==9: byte_valid <= 0, busy <= 0, frame_done <= 1 for exactly one cycle, go to IDLE.
  - Fastest frame (byte_ready held high) is 10 cycles of byte_valid.
- Byte order, index 0..9:
  - 0: HEADER
  - 1–2: x lo, x hi
  - 3–4: y lo, y hi
  - 5–6: set_x lo, set_x hi
  - 7–8: set_y lo, set_y hi
  - 9: checksum = sum of bytes 1..8 mod 256
- All data and checksum bytes come from the snapshot. Input changes mid-frame have no effect.
- Drop rule:
  - req=1 with enable=1 while state==SEND → drop_cnt <= drop_cnt+1, saturating at 8'hFF.
  - This includes the edge where the final byte is accepted, because the block returns to IDLE only on the following cycle.
- frame_done is 0 in every cycle except the one following the final handshake.
- A new frame may start on the edge immediately after frame_done rises (req in the frame_done cycle is accepted).
- Reset mid-frame: outputs and state return to reset values immediately. Bytes of the partial frame are not re-sent.

Test Plan:
- Basic frame: x=16'h1234, y=16'hABCD, set_x=16'h0100, set_y=16'h00FF, enable=1, byte_ready=1, single send_tick → bytes A5 34 12 CD AB 00 01 FF 00 BE on 10 consecutive cycles; frame_done pulse one cycle after BE is accepted; busy falls with it.
- Backpressure: same inputs, byte_ready toggled 1/0/0/1 pseudo-randomly → identical byte sequence; byte_data stable while byte_valid=1 and byte_ready=0; inputs changed to 0 mid-frame do not alter any byte.
- Drops: three send_ticks during a frame, one coinciding with the final handshake → drop_cnt=3 and no extra frame starts; 300 ticks while byte_ready is held at 0 → drop_cnt saturates at 8'hFF.
- Enable gating: enable=0 with send_tick pulses → no byte_valid and drop_cnt unchanged; enable dropped to 0 mid-frame → frame completes all 10 bytes.
- Auto period: AUTO_PERIOD=20, byte_ready=1, no send_tick → byte_valid first high at cycle 20 after reset release, and a frame starts every 20 cycles with drop_cnt=0.
- Reset mid-frame: assert rst after byte 4 is accepted → byte_valid, busy and drop_cnt are 0 in the same cycle; after release, a send_tick produces a full frame starting with A5.
